ascon_tag_verify: RTL and testbench

ASCON_TAG_VERIFY -- requirements
Module: ascon_tag_verify

---
 rtl/ascon_tag_verify.sv | 168 ++++++++++++++++
 tb/tb_ascon_tag_verify.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_tag_verify.sv
// Holds decrypted ASCON plaintext until the computed tag matches the expected tag.
// Plaintext is released only on a match; a mismatch or a buffer overflow discards the message.
module ascon_tag_verify #(
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   ct_data,
    input  logic          ct_valid,
    input  logic          ct_last,
    input  logic [127:0]  tag,
    input  logic          tag_valid,
    input  logic [31:0]   exp_in,
    input  logic          exp_valid,
    output logic          exp_ready,
    output logic [31:0]   pt_out,
    output logic          pt_valid,
    output logic          pt_last,
    input  logic          pt_ready,
    output logic          auth_ok,
    output logic          auth_fail
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {StCollect, StWaitTag, StCompare, StRelease, StFail} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [2:0]     exp_cnt_q, exp_cnt_d;
    logic [127:0]   exp_q, exp_d, tag_q, tag_d;
    logic           tag_seen_q, tag_seen_d, overflow_q, overflow_d;
    logic           clear, buf_we;
    logic [31:0]    buffer [DEPTH];

    logic [31:0]    pt_out_d;
    logic           pt_valid_d, pt_last_d, exp_ready_d, auth_ok_d, auth_fail_d;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        exp_cnt_d  = exp_cnt_q;
        exp_d      = exp_q;
        tag_d      = tag_q;
        tag_seen_d = tag_seen_q;
        overflow_d = overflow_q;
        clear      = 1'b0;
        buf_we     = 1'b0;
        unique case (state_q)
            StCollect, StWaitTag: begin
                if (exp_valid && exp_ready) begin
                    case (exp_cnt_q[1:0])
                        2'd0:    exp_d[127:96] = exp_in;
                        2'd1:    exp_d[95:64]  = exp_in;
                        2'd2:    exp_d[63:32]  = exp_in;
                        default: exp_d[31:0]   = exp_in;
                    endcase
                    exp_cnt_d = exp_cnt_q + 3'd1;
                end
                if (tag_valid) begin
                    tag_d      = tag;
                    tag_seen_d = 1'b1;
                end
                if (state_q == StCollect) begin
                    if (ct_valid) begin
                        if (wr_cnt_q == CW'(DEPTH)) begin
                            overflow_d = 1'b1;
                        end else begin
                            buf_we   = 1'b1;
                            wr_cnt_d = wr_cnt_q + CW'(1);
                        end
                        if (ct_last) state_d = StWaitTag;
                    end else if (tag_valid && wr_cnt_q == '0) begin
                        // Tag with nothing collected: empty message.
                        state_d = StWaitTag;
                    end
                end else begin
                    if (ct_valid) overflow_d = 1'b1;
                    if (tag_seen_q && exp_cnt_q == 3'd4) state_d = StCompare;
                end
            end
            StCompare: begin
                if (tag_q == exp_q && !overflow_q) begin
                    if (wr_cnt_q == '0) begin
                        state_d = StCollect;
                        clear   = 1'b1;
                    end else begin
                        state_d = StRelease;
                    end
                end else begin
                    state_d = StFail;
                end
            end
            StRelease: begin
                if (pt_valid && pt_ready) begin
                    if (pt_last) begin
                        state_d = StCollect;
                        clear   = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end
            StFail: begin
                state_d = StCollect;
                clear   = 1'b1;
            end
            default: state_d = StCollect;
        endcase
        if (clear) begin
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            exp_cnt_d  = '0;
            tag_seen_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_comb begin
        pt_valid_d  = (state_d == StRelease);
        pt_last_d   = pt_valid_d && (rd_cnt_d == wr_cnt_d - CW'(1));
        pt_out_d    = pt_valid_d ? buffer[rd_cnt_d[AW-1:0]] : 32'd0;
        exp_ready_d = (state_d == StCollect || state_d == StWaitTag) && (exp_cnt_d < 3'd4);
        auth_ok_d   = (state_d == StCompare) && (tag_d == exp_d) && !overflow_d;
        auth_fail_d = (state_d == StFail);
    end

    always_ff @(posedge clk) begin
        if (buf_we) buffer[wr_cnt_q[AW-1:0]] <= ct_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StCollect;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            exp_cnt_q  <= '0;
            exp_q      <= '0;
            tag_q      <= '0;
            tag_seen_q <= 1'b0;
            overflow_q <= 1'b0;
            exp_ready  <= 1'b0;
            pt_out     <= '0;
            pt_valid   <= 1'b0;
            pt_last    <= 1'b0;
            auth_ok    <= 1'b0;
            auth_fail  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
            exp_q      <= exp_d;
            tag_q      <= tag_d;
            tag_seen_q <= tag_seen_d;
            overflow_q <= overflow_d;
            exp_ready  <= exp_ready_d;
            pt_out     <= pt_out_d;
            pt_valid   <= pt_valid_d;
            pt_last    <= pt_last_d;
            auth_ok    <= auth_ok_d;
            auth_fail  <= auth_fail_d;
        end
    end

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Directed bench for ascon_tag_verify: match, mismatch, overflow, backpressure,
// early tag ordering, empty message and asynchronous reset during release.
module tb_ascon_tag_verify;
    localparam int DEPTH = 16;

    logic          clk, rst;
    logic [31:0]   ct_data;
    logic          ct_valid, ct_last;
    logic [127:0]  tag;
    logic          tag_valid;
    logic [31:0]   exp_in;
    logic          exp_valid, exp_ready;
    logic [31:0]   pt_out;
    logic          pt_valid, pt_last, pt_ready;
    logic          auth_ok, auth_fail;

    ascon_tag_verify #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_last   (ct_last),
        .tag       (tag),
        .tag_valid (tag_valid),
        .exp_in    (exp_in),
        .exp_valid (exp_valid),
        .exp_ready (exp_ready),
        .pt_out    (pt_out),
        .pt_valid  (pt_valid),
        .pt_last   (pt_last),
        .pt_ready  (pt_ready),
        .auth_ok   (auth_ok),
        .auth_fail (auth_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    localparam logic [127:0] T = 128'h0123456789abcdef_0011223344556677;

    logic [31:0] msg [32];
    bit          bp_mode;
    int          bp_idx;
    logic [3:0]  bp_pat;

    // Monitor: counts pulses, records handshakes, checks stall stability and idle zeroing.
    int          ok_cnt, fail_cnt, cyc;
    logic [31:0] got_q [$];
    logic        last_q [$];
    int          hs_cyc [$];
    logic        stall_prev, fail_prev, prev_last;
    logic [31:0] prev_out;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            stall_prev = 1'b0;
            fail_prev  = 1'b0;
        end else begin
            if (stall_prev)
                check("pt_stable", {pt_valid, pt_last, pt_out}, {1'b1, prev_last, prev_out});
            if (fail_prev) check("exp_ready_after_fail", exp_ready, 1);
            if (!pt_valid) check("pt_out_zero", pt_out, 0);
            if (auth_ok) ok_cnt++;
            if (auth_fail) fail_cnt++;
            if (pt_valid && pt_ready) begin
                got_q.push_back(pt_out);
                last_q.push_back(pt_last);
                hs_cyc.push_back(cyc);
            end
            stall_prev = pt_valid && !pt_ready;
            prev_out   = pt_out;
            prev_last  = pt_last;
            fail_prev  = auth_fail;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        pt_ready = bp_mode ? bp_pat[bp_idx % 4] : 1'b1;
        bp_idx++;
    endtask

    task automatic send_ct(input int lo, input int hi, input int n, input bit tag_last);
        for (int i = lo; i < hi; i++) begin
            ct_data   = msg[i];
            ct_valid  = 1'b1;
            ct_last   = (i == n - 1);
            tag_valid = tag_last && (i == n - 1);
            tick();
        end
        ct_valid  = 1'b0;
        ct_last   = 1'b0;
        tag_valid = 1'b0;
        ct_data   = '0;
    endtask

    task automatic send_exp(input logic [127:0] e);
        for (int k = 0; k < 4; k++) begin
            check("exp_ready", exp_ready, 1);
            exp_in    = e[127 - 32 * k -: 32];
            exp_valid = 1'b1;
            tick();
        end
        exp_valid = 1'b0;
        exp_in    = '0;
    endtask

    task automatic pulse_tag;
        tag_valid = 1'b1;
        tick();
        tag_valid = 1'b0;
    endtask

    task automatic clear_mon;
        ok_cnt   = 0;
        fail_cnt = 0;
        got_q.delete();
        last_q.delete();
        hs_cyc.delete();
    endtask

    task automatic run_msg(input int n, input logic [127:0] t, input logic [127:0] e,
                           input bit early);
        bit done;
        tag = t;
        clear_mon();
        if (early) begin
            send_ct(0, 1, n, 1'b0);
            pulse_tag();
            send_exp(e);
            send_ct(1, n, n, 1'b0);
            tick();
            check("lat_compare", auth_ok, 1);
            tick();
            check("lat_first_pt", pt_valid, 1);
        end else if (n == 0) begin
            pulse_tag();
            send_exp(e);
        end else begin
            send_ct(0, n, n, 1'b1);
            send_exp(e);
        end
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            done = (fail_cnt > 0) || (ok_cnt > 0 && got_q.size() >= n);
        end
        check("msg_done", done, 1);
        repeat (4) tick();
    endtask

    task automatic verify_pass2(input string nm);
        check({nm, "_ok"}, ok_cnt, 1);
        check({nm, "_fail"}, fail_cnt, 0);
        check({nm, "_count"}, got_q.size(), 2);
        if (got_q.size() == 2) begin
            check({nm, "_w0"}, got_q[0], 32'h6e000000);
            check({nm, "_w1"}, got_q[1], 32'h6173636f);
            check({nm, "_last0"}, last_q[0], 0);
            check({nm, "_last1"}, last_q[1], 1);
            check({nm, "_consec"}, hs_cyc[1] - hs_cyc[0], 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        ct_data   = '0;
        ct_valid  = 1'b0;
        ct_last   = 1'b0;
        tag       = '0;
        tag_valid = 1'b0;
        exp_in    = '0;
        exp_valid = 1'b0;
        pt_ready  = 1'b1;
        bp_mode   = 1'b0;
        bp_idx    = 0;
        bp_pat    = 4'b1001;
        msg[0]    = 32'h6e000000;
        msg[1]    = 32'h6173636f;
        for (int i = 2; i < 32; i++) msg[i] = 32'ha5000000 | i;

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #2 rst = 1'b0;
        #1;
        check("reset_async", {exp_ready, pt_valid, pt_last, auth_ok, auth_fail, pt_out}, 0);
        repeat (3) tick();
        check("reset_hold", {exp_ready, pt_valid, pt_last, auth_ok, auth_fail, pt_out}, 0);
        rst = 1'b1;
        tick();
        check("exp_ready_after_reset", exp_ready, 1);

        run_msg(2, T, T, 1'b0);
        verify_pass2("match");

        run_msg(2, T, T ^ 128'h1, 1'b0);
        check("mismatch_fail", fail_cnt, 1);
        check("mismatch_ok", ok_cnt, 0);
        check("mismatch_no_pt", got_q.size(), 0);

        run_msg(DEPTH + 1, T, T, 1'b0);
        check("overflow_fail", fail_cnt, 1);
        check("overflow_ok", ok_cnt, 0);
        check("overflow_no_pt", got_q.size(), 0);

        bp_mode = 1'b1;
        bp_idx  = 0;
        run_msg(4, T, T, 1'b0);
        bp_mode = 1'b0;
        check("bp_ok", ok_cnt, 1);
        check("bp_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("bp_word", got_q[i], msg[i]);
                check("bp_last", last_q[i], (i == 3));
            end
        end

        run_msg(2, T, T, 1'b1);
        verify_pass2("early");

        run_msg(0, T, T, 1'b0);
        check("empty_ok", ok_cnt, 1);
        check("empty_fail", fail_cnt, 0);
        check("empty_no_pt", got_q.size(), 0);

        // Reset after the first plaintext handshake.
        tag = T;
        clear_mon();
        send_ct(0, 2, 2, 1'b1);
        send_exp(T);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            tick();
            seen = (got_q.size() >= 1);
        end
        check("rst_mid_first_hs", seen, 1);
        check("rst_mid_pre_valid", pt_valid, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_async", {exp_ready, pt_valid, pt_last, auth_ok, auth_fail, pt_out}, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        run_msg(2, T, T, 1'b0);
        verify_pass2("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
